// File: rtl/alu_op_writer_if.sv
// Request handshake plus write-side memory bus of the ALU command writer.
// "master" is the writer's view; "slave" is the requester/memory side.
interface alu_op_writer_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] req_a;
  logic [DATA_WIDTH-1:0] req_b;
  logic [2:0]            req_oper;
  logic                  mem_enable;
  logic                  mem_rd_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic                  busy;
  logic                  done;
  logic [7:0]            req_count;

  modport master (
    input  req_valid, req_a, req_b, req_oper,
    output req_ready, mem_enable, mem_rd_wr, mem_addr, mem_wr_data,
           busy, done, req_count
  );

  modport slave (
    output req_valid, req_a, req_b, req_oper,
    input  req_ready, mem_enable, mem_rd_wr, mem_addr, mem_wr_data,
           busy, done, req_count
  );
endinterface

// File: rtl/alu_op_writer.sv
// Writes A, B, oper and execute=1 into the 4-word ALU command memory, releases
// the bus for HOLD_CYCLES cycles, then clears execute and pulses done.
module alu_op_writer #(
  parameter int ADDR_WIDTH  = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  alu_op_writer_if.master  bus
);
  typedef enum logic [2:0] {
    IDLE, WR_A, WR_B, WR_OPER, WR_EXEC, HOLD, CLR_EXEC
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_A    = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_B    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_OPER = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_EXEC = ADDR_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] EXEC_ON   = DATA_WIDTH'(1);
  localparam logic [7:0]            HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t                state_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [2:0]            oper_q;
  logic [7:0]            hold_cnt_q;
  logic                  req_ready_q;
  logic                  mem_enable_q;
  logic                  mem_rd_wr_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wr_data_q;
  logic                  busy_q;
  logic                  done_q;
  logic [7:0]            req_count_q;

  logic [7:0]            hold_cnt_d;
  logic [7:0]            req_count_d;
  logic [DATA_WIDTH-1:0] oper_ext_d;

  assign hold_cnt_d  = hold_cnt_q - 8'd1;
  assign req_count_d = req_count_q + 8'd1;
  assign oper_ext_d  = DATA_WIDTH'(oper_q);

  // Bus outputs default to "released" (read, addr 0, data 0) every cycle;
  // only the write states override them, so rd_wr is never 0 with enable 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      b_q           <= '0;
      oper_q        <= '0;
      hold_cnt_q    <= '0;
      req_ready_q   <= 1'b0;
      mem_enable_q  <= 1'b0;
      mem_rd_wr_q   <= 1'b1;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      req_count_q   <= '0;
    end else begin
      mem_enable_q  <= 1'b0;
      mem_rd_wr_q   <= 1'b1;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      done_q        <= 1'b0;
      unique case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            state_q       <= WR_A;
            b_q           <= bus.req_b;
            oper_q        <= bus.req_oper;
            req_ready_q   <= 1'b0;
            busy_q        <= 1'b1;
            mem_enable_q  <= 1'b1;
            mem_rd_wr_q   <= 1'b0;
            mem_addr_q    <= ADDR_A;
            mem_wr_data_q <= bus.req_a;
          end
        end
        WR_A: begin
          state_q       <= WR_B;
          mem_enable_q  <= 1'b1;
          mem_rd_wr_q   <= 1'b0;
          mem_addr_q    <= ADDR_B;
          mem_wr_data_q <= b_q;
        end
        WR_B: begin
          state_q       <= WR_OPER;
          mem_enable_q  <= 1'b1;
          mem_rd_wr_q   <= 1'b0;
          mem_addr_q    <= ADDR_OPER;
          mem_wr_data_q <= oper_ext_d;
        end
        WR_OPER: begin
          state_q       <= WR_EXEC;
          mem_enable_q  <= 1'b1;
          mem_rd_wr_q   <= 1'b0;
          mem_addr_q    <= ADDR_EXEC;
          mem_wr_data_q <= EXEC_ON;
        end
        WR_EXEC: begin
          state_q    <= HOLD;
          hold_cnt_q <= HOLD_LOAD;
        end
        HOLD: begin
          if (hold_cnt_q == 8'd0) begin
            state_q      <= CLR_EXEC;
            mem_enable_q <= 1'b1;
            mem_rd_wr_q  <= 1'b0;
            mem_addr_q   <= ADDR_EXEC;
            done_q       <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_d;
          end
        end
        CLR_EXEC: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
          req_count_q <= req_count_d;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.mem_enable  = mem_enable_q;
  assign bus.mem_rd_wr   = mem_rd_wr_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.req_count   = req_count_q;
endmodule

// File: tb/tb_alu_op_writer.sv
// Two writers (HOLD_CYCLES 4 and 1) driven by random and directed requests and
// compared every cycle against a cycle-offset timeline model of a transaction.
module tb_alu_op_writer;
  localparam int AW = 2;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_op_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if4 ();
  alu_op_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();

  alu_op_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HOLD_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .bus(if4.master));
  alu_op_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.master));

  // Request inputs, index 0 -> HOLD 4 writer, index 1 -> HOLD 1 writer
  logic       v [2];
  logic [7:0] ra[2];
  logic [7:0] rb[2];
  logic [2:0] ro[2];

  assign if4.req_valid = v[0];
  assign if4.req_a     = ra[0];
  assign if4.req_b     = rb[0];
  assign if4.req_oper  = ro[0];
  assign if1.req_valid = v[1];
  assign if1.req_a     = ra[1];
  assign if1.req_b     = rb[1];
  assign if1.req_oper  = ro[1];

  // Packed outputs: [22] ready [21] enable [20] rd_wr [19:18] addr
  // [17:10] wr_data [9] busy [8] done [7:0] req_count
  logic [22:0] act[2];
  assign act[0] = {if4.req_ready, if4.mem_enable, if4.mem_rd_wr, if4.mem_addr,
                   if4.mem_wr_data, if4.busy, if4.done, if4.req_count};
  assign act[1] = {if1.req_ready, if1.mem_enable, if1.mem_rd_wr, if1.mem_addr,
                   if1.mem_wr_data, if1.busy, if1.done, if1.req_count};

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expv);
    n_checks++;
    if (actual === expv) n_pass++;
    else $display("FAIL %s: actual %0h, required %0h", name, actual, expv);
  endtask

  function automatic int hold_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  // Model: m_phase = cycles since the accept edge (0 = idle); a transaction
  // lasts 5+H cycles after accept, as laid out in the latency rules.
  int         m_phase[2];
  logic       m_live [2];
  logic [7:0] m_a[2], m_b[2], m_cnt[2];
  logic [2:0] m_op[2];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        m_phase[d] <= 0;
        m_live[d]  <= 1'b0;
        m_cnt[d]   <= 8'd0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_live[d] <= 1'b1;
        if (m_phase[d] == 0) begin
          if (m_live[d] && v[d]) begin
            m_phase[d] <= 1;
            m_a[d] <= ra[d]; m_b[d] <= rb[d]; m_op[d] <= ro[d];
          end
        end else if (m_phase[d] == 5 + hold_of(d)) begin
          m_phase[d] <= 0;
          m_cnt[d]   <= m_cnt[d] + 8'd1;
        end else begin
          m_phase[d] <= m_phase[d] + 1;
        end
      end
    end
  end

  function automatic logic [22:0] expect_out(input int d);
    int k, last;
    logic en, rdy;
    logic [1:0] addr;
    logic [7:0] data;
    k    = m_phase[d];
    last = 5 + hold_of(d);
    en   = (k >= 1 && k <= 4) || (k == last);
    addr = (k >= 1 && k <= 4) ? 2'(k - 1) : ((k == last) ? 2'd3 : 2'd0);
    case (k)
      1: data = m_a[d];
      2: data = m_b[d];
      3: data = {5'd0, m_op[d]};
      4: data = 8'd1;
      default: data = 8'd0;
    endcase
    rdy = m_live[d] && (k == 0);
    return {rdy, en, ~en, addr, data, (k != 0), (k == last), m_cnt[d]};
  endfunction

  // Memory as seen by the bus
  logic [7:0] mem[2][4];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      if (reset && act[d][21] && !act[d][20]) mem[d][act[d][19:18]] <= act[d][17:10];
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      string nm;
      nm = (d == 0) ? "outputs_h4" : "outputs_h1";
      chk(nm, 32'(act[d]), 32'(expect_out(d)));
      if (act[d] [8] === 1'b1)
        $display("txn h%0d: a=%02h b=%02h op=%0d count_before=%0d", hold_of(d),
                 m_a[d], m_b[d], m_op[d], act[d][7:0]);
    end
  end

  task automatic wait_ready(input int d);
    for (int i = 0; i < 50 && act[d][22] !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic run_single(input int d, input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] o, output int done_k, output int ready_k);
    wait_ready(d);
    v[d] = 1'b1; ra[d] = a; rb[d] = b; ro[d] = o;
    @(posedge clk);
    done_k = -1; ready_k = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        v[d] = 1'b0; ra[d] = 8'($urandom); rb[d] = 8'($urandom); ro[d] = 3'($urandom);
      end
      if (k == 5) begin
        chk("hold_enable_low", 32'(act[d][21]), 32'd0);
        chk("hold_exec_word", 32'(mem[d][3]), 32'd1);
      end
      if (act[d][8] === 1'b1 && done_k < 0) done_k = k;
      if (done_k > 0 && act[d][22] === 1'b1 && ready_k < 0) ready_k = k;
      if (ready_k > 0) break;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_k, ready_k, na, nd, first_done, last_done;
    int acc[3];
    for (int d = 0; d < 2; d++) begin
      v[d] = 1'b0; ra[d] = '0; rb[d] = '0; ro[d] = '0;
    end
    acc = '{0, 0, 0};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ready",  32'(act[0][22]), 32'd0);
    chk("rst_enable", 32'(act[0][21]), 32'd0);
    chk("rst_rd_wr",  32'(act[0][20]), 32'd1);
    chk("rst_count",  32'(act[0][7:0]), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_release_h4", 32'(act[0][22]), 32'd1);
    chk("ready_after_release_h1", 32'(act[1][22]), 32'd1);
    repeat (3) @(negedge clk);

    // Single request, default hold
    run_single(0, 8'h12, 8'h34, 3'd3, done_k, ready_k);
    chk("h4_done_cycle",  32'(done_k), 32'd9);
    chk("h4_ready_cycle", 32'(ready_k), 32'd10);
    chk("h4_mem_a",    32'(mem[0][0]), 32'h12);
    chk("h4_mem_b",    32'(mem[0][1]), 32'h34);
    chk("h4_mem_oper", 32'(mem[0][2]), 32'h03);
    chk("h4_mem_exec", 32'(mem[0][3]), 32'h00);
    chk("h4_count_1",  32'(act[0][7:0]), 32'd1);

    // Single request, one-cycle hold
    run_single(1, 8'hA5, 8'h5A, 3'd7, done_k, ready_k);
    chk("h1_done_cycle",  32'(done_k), 32'd6);
    chk("h1_ready_cycle", 32'(ready_k), 32'd7);
    chk("h1_mem_oper", 32'(mem[1][2]), 32'h07);
    chk("h1_count_1",  32'(act[1][7:0]), 32'd1);

    // valid held high: three back-to-back accepts, inputs scrambled every cycle
    na = 0;
    v[0] = 1'b1;
    for (int i = 0; i < 100 && na < 3; i++) begin
      @(negedge clk);
      ra[0] = 8'($urandom); rb[0] = 8'($urandom); ro[0] = 3'($urandom);
      if (act[0][22] === 1'b1) begin
        @(posedge clk);
        acc[na] = cyc;
        na++;
      end
    end
    v[0] = 1'b0;
    for (int i = 0; i < 30 && act[0][9] !== 1'b0; i++) @(negedge clk);
    chk("b2b_accepts", 32'(na), 32'd3);
    chk("b2b_period_1", 32'(acc[1] - acc[0]), 32'd10);
    chk("b2b_period_2", 32'(acc[2] - acc[1]), 32'd10);
    chk("b2b_count", 32'(act[0][7:0]), 32'd4);

    // valid pulsed during WR_B and HOLD is ignored
    wait_ready(0);
    v[0] = 1'b1; ra[0] = 8'h77; rb[0] = 8'h88; ro[0] = 3'd5;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      v[0] = (k == 2 || k == 6);
      ra[0] = 8'($urandom);
    end
    chk("busy_pulse_count", 32'(act[0][7:0]), 32'd5);

    // Random traffic on both writers
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        v[d]  = ($urandom_range(0, 3) == 0);
        ra[d] = 8'($urandom); rb[d] = 8'($urandom); ro[d] = 3'($urandom);
      end
    end
    v[0] = 1'b0; v[1] = 1'b0;
    repeat (15) @(negedge clk);

    // Reset during HOLD (cycle 6)
    wait_ready(0);
    v[0] = 1'b1; ra[0] = 8'h3C; rb[0] = 8'hC3; ro[0] = 3'd2;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) v[0] = 1'b0;
    end
    chk("pre_rst_busy", 32'(act[0][9]), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_enable", 32'(act[0][21]), 32'd0);
    chk("mid_rst_busy",   32'(act[0][9]), 32'd0);
    chk("mid_rst_rd_wr",  32'(act[0][20]), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(act[0][22]), 32'd1);
    chk("post_rst_count", 32'(act[0][7:0]), 32'd0);
    repeat (4) @(negedge clk);
    chk("post_rst_exec_left", 32'(mem[0][3]), 32'd1);

    // 256 back-to-back transactions with HOLD 1: wrap and 7-cycle period
    nd = 0; first_done = 0; last_done = 0;
    v[1] = 1'b1;
    for (int i = 0; i < 256 * 7 + 60 && nd < 256; i++) begin
      @(negedge clk);
      ra[1] = 8'($urandom); rb[1] = 8'($urandom); ro[1] = 3'($urandom);
      if (act[1][8] === 1'b1) begin
        if (nd == 0) first_done = cyc;
        last_done = cyc;
        nd++;
      end
    end
    v[1] = 1'b0;
    repeat (10) @(negedge clk);
    chk("wrap_done_count", 32'(nd), 32'd256);
    chk("wrap_span", 32'(last_done - first_done), 32'd1785);
    chk("wrap_count_zero", 32'(act[1][7:0]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
